uart_rx_deserializer: RTL and testbench

- Receive-side serial front end of the UART: oversamples the asynchronous rx line, detects start bits, deserialises LSB-first data, and checks parity and stop bits.
- Delivers each good frame as a parallel word plus a one-cycle strobe. Sits directly upstream of the receive FIFO and drives its Rx_Data / Data_Rdy inputs.
- Shares BIST_Mode with the FIFO; the receiver is inert while BIST is active.

---
 rtl/uart_rx_deserializer.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronises and oversamples rx_in, frames start/data/parity/stop,
// and hands each good word to the downstream FIFO with a one-cycle Data_Rdy strobe.
module uart_rx_deserializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  input  logic                 BIST_Mode,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Data_Rdy,
  output logic                 Parity_Err,
  output logic                 Frame_Err,
  output logic                 Busy
);

  // state   | meaning
  // IDLE    | waiting for a falling edge on the synchronised line
  // START   | confirming the start bit at its mid-point
  // DATA    | sampling DATA_BITS data bits, LSB first
  // PARITY  | sampling the parity bit
  // STOP    | sampling the stop bit and publishing the frame result
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  state_e state_q, state_d;

  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rdy_q, rdy_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  logic fall_edge, mid_tick, bit_tick, par_err;

  assign fall_edge = rx_prev_q && !rx_s_q;
  assign mid_tick  = baud_tick && (cnt_q == CNT_HALF);
  assign bit_tick  = baud_tick && (cnt_q == CNT_LAST);
  assign par_err   = (PARITY_EN != 0) && ((^shift_q ^ par_bit_q) != (PARITY_ODD != 0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (BIST_Mode) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (fall_edge) state_d = S_START;
        S_START:  if (mid_tick) state_d = rx_s_q ? S_IDLE : S_DATA;
        S_DATA:   if (bit_tick && (bit_idx_q == BIT_LAST))
                    state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        S_PARITY: if (bit_tick) state_d = S_STOP;
        S_STOP:   if (bit_tick) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    rx_data_d = rx_data_q;
    rdy_d     = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    // The counter restarts on every state change and wraps inside a bit period.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (baud_tick && (state_q != S_IDLE)) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    if (!BIST_Mode) begin
      case (state_q)
        S_START: if (mid_tick) bit_idx_d = '0;
        S_DATA: begin
          if (bit_tick) begin
            shift_d                = shift_q >> 1;
            shift_d[DATA_BITS-1]   = rx_s_q;
            bit_idx_d              = bit_idx_q + 1'b1;
          end
        end
        S_PARITY: if (bit_tick) par_bit_d = rx_s_q;
        S_STOP: begin
          if (bit_tick) begin
            perr_d = par_err;
            if (rx_s_q) begin
              rx_data_d = shift_q;
              rdy_d     = 1'b1;
              ferr_d    = 1'b0;
            end else begin
              ferr_d    = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      rx_data_q <= '0;
      rdy_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      // rx_prev_q keeps tracking during BIST so a release on a low line is not an edge.
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    Busy       = (state_q != S_IDLE);
    Rx_Data    = rx_data_q;
    Data_Rdy   = rdy_q;
    Parity_Err = perr_q;
    Frame_Err  = ferr_q;
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: drives serial frames bit by bit and checks every cycle against
// a frame-level model (expected deliveries queue plus last-frame flag state).
module tb_uart_rx_deserializer;
  localparam int DB = 8;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          rst, baud_tick, rx_in, BIST_Mode;
  logic [DB-1:0] Rx_Data;
  logic          Data_Rdy, Parity_Err, Frame_Err, Busy;

  uart_rx_deserializer #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx_in), .BIST_Mode(BIST_Mode),
    .Rx_Data(Rx_Data), .Data_Rdy(Data_Rdy), .Parity_Err(Parity_Err),
    .Frame_Err(Frame_Err), .Busy(Busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [DB-1:0] d;
    logic          perr;
  } deliv_t;

  int      tests_run = 0;
  int      fails = 0;
  int      tdiv = 4;
  int      pulses = 0;
  deliv_t  exp_q[$];
  logic [DB-1:0] exp_rx = '0;
  logic    exp_perr = 1'b0;
  logic    exp_ferr = 1'b0;
  bit      dc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int tc;
    tc = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tdiv <= 1) baud_tick = 1'b1;
      else begin
        tc = (tc + 1) % tdiv;
        baud_tick = (tc == 0);
      end
    end
  end

  // Per-cycle compare against the frame-level model.
  initial begin
    bit prev_rdy;
    deliv_t e;
    prev_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_rdy = 1'b0;
      end else begin
        if (Data_Rdy) begin
          chk("rdy_back_to_back", {31'd0, prev_rdy}, 32'd0);
          pulses++;
          if (exp_q.size() == 0) begin
            chk("unexpected_rdy", {31'd0, Data_Rdy}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rx_data_on_rdy", {24'd0, Rx_Data}, {24'd0, e.d});
            chk("perr_on_rdy", {31'd0, Parity_Err}, {31'd0, e.perr});
            chk("ferr_on_rdy", {31'd0, Frame_Err}, 32'd0);
            exp_rx = e.d;
          end
        end else begin
          chk("rx_data_hold", {24'd0, Rx_Data}, {24'd0, exp_rx});
          if (!dc) begin
            chk("perr_hold", {31'd0, Parity_Err}, {31'd0, exp_perr});
            chk("ferr_hold", {31'd0, Frame_Err}, {31'd0, exp_ferr});
          end
        end
        prev_rdy = Data_Rdy;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_bit(input logic v);
    rx_in = v;
    repeat (OS * tdiv) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic pbit, input logic sbit);
    logic   pe;
    deliv_t e;
    // Even parity: error when data ones plus parity bit is odd.
    pe = ((($countones(d) + int'(pbit)) % 2) != 0);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    drive_bit(pbit);
    if (sbit) begin
      e.d = d;
      e.perr = pe;
      exp_q.push_back(e);
    end
    dc = 1'b1;
    drive_bit(sbit);
    exp_perr = pe;
    exp_ferr = !sbit;
    dc = 1'b0;
    chk("delivered_once", exp_q.size(), 32'd0);
  endtask

  initial begin
    int p0;
    logic [DB-1:0] d;
    logic pbit, sbit, prev_bad;

    rst = 1'b1;
    BIST_Mode = 1'b0;
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_rx_data", {24'd0, Rx_Data}, 32'd0);
    chk("reset_rdy", {31'd0, Data_Rdy}, 32'd0);
    chk("reset_perr", {31'd0, Parity_Err}, 32'd0);
    chk("reset_ferr", {31'd0, Frame_Err}, 32'd0);
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    rst = 1'b0;
    idle_bits(1);

    // 8E1 0xA5, correct parity
    send_frame(8'hA5, 1'b0, 1'b1);
    idle_bits(1);
    chk("t1_rx_data", {24'd0, Rx_Data}, 32'hA5);
    chk("t1_perr", {31'd0, Parity_Err}, 32'd0);
    chk("t1_ferr", {31'd0, Frame_Err}, 32'd0);
    chk("t1_busy", {31'd0, Busy}, 32'd0);
    chk("t1_pulses", pulses, 32'd1);

    // Bad parity still delivers; next good frame clears the flag
    send_frame(8'hA5, 1'b1, 1'b1);
    idle_bits(1);
    chk("t2_perr_set", {31'd0, Parity_Err}, 32'd1);
    chk("t2_rx_data", {24'd0, Rx_Data}, 32'hA5);
    send_frame(8'h3C, 1'b0, 1'b1);
    idle_bits(1);
    chk("t2_perr_clr", {31'd0, Parity_Err}, 32'd0);
    chk("t2_rx_data2", {24'd0, Rx_Data}, 32'h3C);

    // Framing error followed by a stuck-low line
    send_frame(8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) drive_bit(1'b0);
    chk("t3_ferr", {31'd0, Frame_Err}, 32'd1);
    chk("t3_rx_keep", {24'd0, Rx_Data}, 32'h3C);
    chk("t3_busy", {31'd0, Busy}, 32'd0);
    chk("t3_pulses", pulses, 32'd3);
    idle_bits(2);

    // Start glitch: low for 4 ticks only
    rx_in = 1'b0;
    repeat (4 * tdiv) @(negedge clk);
    chk("t4_glitch_busy", {31'd0, Busy}, 32'd1);
    rx_in = 1'b1;
    repeat (OS * tdiv) @(negedge clk);
    chk("t4_glitch_idle", {31'd0, Busy}, 32'd0);
    chk("t4_ferr_kept", {31'd0, Frame_Err}, 32'd1);
    send_frame(8'h81, 1'b0, 1'b1);
    idle_bits(1);
    chk("t4_rx_data", {24'd0, Rx_Data}, 32'h81);
    chk("t4_ferr_clr", {31'd0, Frame_Err}, 32'd0);

    // Reset after three data bits of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rst = 1'b1;
    rx_in = 1'b1;
    exp_rx = '0;
    exp_perr = 1'b0;
    exp_ferr = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_rst_rx_data", {24'd0, Rx_Data}, 32'd0);
    chk("t5_rst_rdy", {31'd0, Data_Rdy}, 32'd0);
    chk("t5_rst_busy", {31'd0, Busy}, 32'd0);
    chk("t5_rst_perr", {31'd0, Parity_Err}, 32'd0);
    chk("t5_rst_ferr", {31'd0, Frame_Err}, 32'd0);
    rst = 1'b0;
    idle_bits(1);
    p0 = pulses;
    send_frame(8'h3C, 1'b0, 1'b1);
    idle_bits(1);
    chk("t5_one_pulse", pulses - p0, 32'd1);
    chk("t5_rx_data", {24'd0, Rx_Data}, 32'h3C);

    // Back-to-back frames with baud_tick held high, then BIST mid-frame
    tdiv = 1;
    idle_bits(1);
    p0 = pulses;
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFE, 1'b1, 1'b1);
    chk("t6_two_pulses", pulses - p0, 32'd2);
    chk("t6_rx_data", {24'd0, Rx_Data}, 32'hFE);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    BIST_Mode = 1'b1;
    drive_bit(1'b0);
    drive_bit(1'b0);
    BIST_Mode = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_bist_release_low", {31'd0, Busy}, 32'd0);
    drive_bit(1'b0);
    idle_bits(3);
    chk("t6_no_third", pulses - p0, 32'd2);
    chk("t6_busy", {31'd0, Busy}, 32'd0);
    send_frame(8'hC3, 1'b0, 1'b1);
    idle_bits(1);
    chk("t6_recover", {24'd0, Rx_Data}, 32'hC3);

    // Randomised frames: data, parity correctness, stop bit, tick rate and gaps
    prev_bad = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tdiv = $urandom_range(1, 4);
      idle_bits(prev_bad ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2));
      d = DB'($urandom);
      pbit = ($urandom_range(0, 3) != 0) ? ^d : ~^d;
      sbit = ($urandom_range(0, 4) != 0);
      send_frame(d, pbit, sbit);
      prev_bad = !sbit;
    end
    idle_bits(2);
    chk("end_busy", {31'd0, Busy}, 32'd0);
    chk("end_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
